// File: rtl/daq_align_pkg.sv
// Shared types for the aligned-word FIFO stage (writer-side aligner and reader-side splitter).
package daq_align_pkg;

  localparam int DATA_W = 32;
  localparam int WORDS  = 8;
  localparam int LEN_W  = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [WORDS-1:0]  be_t;
  typedef word_t [WORDS-1:0] block_t;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} split_state_e;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             zero;
    logic             non_thermo;
  } be_info_t;

  // (active_lanes + 1) * 2, the longest block the readout path is configured for
  function automatic logic [LEN_W-1:0] lanes_max(input logic [1:0] active_lanes);
    return {1'b0, active_lanes, 1'b0} + LEN_W'(2);
  endfunction

endpackage

// File: rtl/split_data_be_decode.sv
// Word-enable decoder: block length from the highest set enable, plus zero / non-thermometer flags.
module be_decode
  import daq_align_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] be,
  output be_info_t     info
);

  logic [N-1:0] mask;

  always_comb begin
    info = '0;
    mask = '0;
    for (int k = 0; k < N; k++)
      if (be[k]) info.len = LEN_W'(k + 1);
    // a well-formed enable is exactly the low len bits set
    for (int k = 0; k < N; k++)
      mask[k] = (k < int'(info.len));
    info.zero       = (be == '0);
    info.non_thermo = !info.zero && (be != mask);
  end

endmodule

// File: rtl/split_data.sv
// Pops 8-word blocks from a first-word-fall-through store and replays them as a 32-bit stream.
module split_data
  import daq_align_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [1:0]              ActiveLanes,
  input  logic                    InEmpty,
  input  logic [DATA_W*WORDS-1:0] InData,
  input  logic [WORDS-1:0]        InBe,
  input  logic                    InEof,
  output logic                    InRead,
  output logic [DATA_W-1:0]       DataOut,
  output logic                    EofOut,
  output logic                    ValidOut,
  input  logic                    ReadyOut,
  input  logic                    ErrClear,
  output logic                    ErrBe,
  output logic                    ErrLen,
  output logic [CNT_W-1:0]        FrameCount
);

  localparam int SEL_W = $clog2(WORDS);

  logic [WORDS-1:0][DATA_W-1:0] in_words, buf_q;
  split_state_e                 state_q;
  logic                         eof_q, chk_len_q;
  logic [LEN_W-1:0]             idx_q, last_q, lanes_max_q;
  be_info_t                     be_info;
  logic                         accept, last_word, pop, be_err, len_err;

  genvar g;
  generate
    for (g = 0; g < WORDS; g++) begin : g_unpack
      assign in_words[g] = InData[g*DATA_W +: DATA_W];
    end
  endgenerate

  be_decode #(.N(WORDS)) u_be_decode (
    .be   (InBe),
    .info (be_info)
  );

  assign ValidOut  = (state_q == SEND);
  assign last_word = (idx_q == last_q);
  assign accept    = ValidOut & ReadyOut;
  // refill on the same edge the last word leaves, so blocks stream without a bubble
  assign pop       = !InEmpty & ((state_q == IDLE) | (accept & last_word));
  assign InRead    = pop;
  assign DataOut   = buf_q[idx_q[SEL_W-1:0]];
  assign EofOut    = ValidOut & eof_q & last_word;

  assign be_err  = pop & (be_info.zero | be_info.non_thermo);
  // length check runs the cycle after pop against the lane limit captured at pop
  assign len_err = chk_len_q & ((last_q + LEN_W'(1)) > lanes_max_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      eof_q       <= 1'b0;
      idx_q       <= '0;
      last_q      <= '0;
      lanes_max_q <= '0;
      chk_len_q   <= 1'b0;
      ErrBe       <= 1'b0;
      ErrLen      <= 1'b0;
      FrameCount  <= '0;
    end else begin
      chk_len_q <= 1'b0;
      if (accept && !last_word)
        idx_q <= idx_q + LEN_W'(1);
      if (pop) begin
        buf_q       <= in_words;
        eof_q       <= InEof;
        idx_q       <= '0;
        last_q      <= be_info.len - LEN_W'(1);
        lanes_max_q <= lanes_max(ActiveLanes);
        chk_len_q   <= !be_info.zero;
        // an all-zero enable carries nothing: drop it and stay idle
        state_q     <= be_info.zero ? IDLE : SEND;
      end else if (accept && last_word) begin
        state_q <= IDLE;
      end

      if (be_err)        ErrBe <= 1'b1;
      else if (ErrClear) ErrBe <= 1'b0;
      if (len_err)       ErrLen <= 1'b1;
      else if (ErrClear) ErrLen <= 1'b0;

      if (accept && EofOut)
        FrameCount <= FrameCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_split_data.sv
// Directed bench for split_data: vector table of single blocks plus streaming/stall/reset/wrap sequences.
module tb_split_data;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [1:0]   ActiveLanes = 2'd3;
  logic         InEmpty = 1'b1;
  logic [255:0] InData = '0;
  logic [7:0]   InBe = '0;
  logic         InEof = 1'b0;
  logic         InRead;
  logic [31:0]  DataOut;
  logic         EofOut, ValidOut;
  logic         ReadyOut = 1'b1;
  logic         ErrClear = 1'b0;
  logic         ErrBe, ErrLen;
  logic [15:0]  FrameCount;

  logic         w_InRead, w_EofOut, w_ValidOut, w_ErrBe, w_ErrLen;
  logic [31:0]  w_DataOut;
  logic [3:0]   w_FrameCount;

  always #5 Clk = ~Clk;

  split_data #(.DATA_W(32), .WORDS(8), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ActiveLanes(ActiveLanes), .InEmpty(InEmpty),
    .InData(InData), .InBe(InBe), .InEof(InEof), .InRead(InRead),
    .DataOut(DataOut), .EofOut(EofOut), .ValidOut(ValidOut), .ReadyOut(ReadyOut),
    .ErrClear(ErrClear), .ErrBe(ErrBe), .ErrLen(ErrLen), .FrameCount(FrameCount)
  );

  // narrow counter copy, same stimulus, to exercise the FrameCount wrap cheaply
  split_data #(.DATA_W(32), .WORDS(8), .CNT_W(4)) dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .ActiveLanes(ActiveLanes), .InEmpty(InEmpty),
    .InData(InData), .InBe(InBe), .InEof(InEof), .InRead(w_InRead),
    .DataOut(w_DataOut), .EofOut(w_EofOut), .ValidOut(w_ValidOut), .ReadyOut(ReadyOut),
    .ErrClear(ErrClear), .ErrBe(w_ErrBe), .ErrLen(w_ErrLen), .FrameCount(w_FrameCount)
  );

  typedef struct { logic [7:0] be; logic eof; logic [31:0] base; } blk_t;
  typedef struct { logic [31:0] d; logic e; int cyc; } acc_t;
  typedef struct {
    logic [7:0] be; logic eof; logic [1:0] lanes; int nwords; logic ebe; logic elen;
  } vec_t;

  blk_t up_q[$];
  acc_t acc_q[$];
  int   nchk = 0, nbad = 0, nreads = 0, illegal = 0, cyc = 0, fc_exp = 0;
  logic pop_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_head();
    if (up_q.size() == 0) begin
      InEmpty = 1'b1;
      InBe    = '0;
      InEof   = 1'b0;
      InData  = '0;
    end else begin
      InEmpty = 1'b0;
      InBe    = up_q[0].be;
      InEof   = up_q[0].eof;
      for (int k = 0; k < 8; k++) InData[k*32 +: 32] = up_q[0].base + 32'(k);
    end
  endtask

  task automatic push(input logic [7:0] be, input logic eof, input logic [31:0] base);
    blk_t b;
    b.be = be; b.eof = eof; b.base = base;
    up_q.push_back(b);
    drive_head();
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((up_q.size() != 0 || ValidOut) && n < 60) begin
      step();
      n++;
    end
    chk("done_timeout", 64'(n < 60), 64'd1);
    step();
  endtask

  always @(posedge Clk) cyc++;

  always @(negedge Clk)
    if (Reset_n && ValidOut && ReadyOut) acc_q.push_back('{DataOut, EofOut, cyc});

  // upstream FWFT model: pop seen before the edge, head advanced just after it
  initial forever begin
    @(negedge Clk);
    pop_seen = InRead;
    if (InRead && InEmpty) illegal++;
    @(posedge Clk);
    #1;
    if (pop_seen && up_q.size() > 0) begin
      up_q.delete(0);
      nreads++;
      drive_head();
    end
  end

  vec_t vt[11];

  initial begin
    int   r0;
    logic [31:0] base;

    vt[0]  = '{8'h0F, 1'b1, 2'd3, 4, 1'b0, 1'b0};
    vt[1]  = '{8'h00, 1'b1, 2'd3, 0, 1'b1, 1'b0};
    vt[2]  = '{8'h05, 1'b0, 2'd3, 3, 1'b1, 1'b0};
    vt[3]  = '{8'h07, 1'b1, 2'd0, 3, 1'b0, 1'b1};
    vt[4]  = '{8'h07, 1'b1, 2'd3, 3, 1'b0, 1'b0};
    vt[5]  = '{8'hFF, 1'b1, 2'd3, 8, 1'b0, 1'b0};
    vt[6]  = '{8'h01, 1'b1, 2'd0, 1, 1'b0, 1'b0};
    vt[7]  = '{8'h0F, 1'b0, 2'd1, 4, 1'b0, 1'b0};
    vt[8]  = '{8'h1F, 1'b1, 2'd1, 5, 1'b0, 1'b1};
    vt[9]  = '{8'h80, 1'b1, 2'd3, 8, 1'b1, 1'b0};
    vt[10] = '{8'h3F, 1'b1, 2'd2, 6, 1'b0, 1'b0};

    #1;
    chk("rst_valid", 64'(ValidOut), 0);
    chk("rst_eof", 64'(EofOut), 0);
    chk("rst_data", 64'(DataOut), 0);
    chk("rst_inread", 64'(InRead), 0);
    chk("rst_errbe", 64'(ErrBe), 0);
    chk("rst_errlen", 64'(ErrLen), 0);
    chk("rst_fc", 64'(FrameCount), 0);
    step(); step();
    Reset_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      ErrClear = 1'b1; step(); ErrClear = 1'b0; step();
      chk($sformatf("v%0d_clr_errbe", i), 64'(ErrBe), 0);
      chk($sformatf("v%0d_clr_errlen", i), 64'(ErrLen), 0);
      acc_q.delete();
      r0 = nreads;
      ActiveLanes = vt[i].lanes;
      base = 32'hA000_0000 + 32'(i * 256);
      push(vt[i].be, vt[i].eof, base);
      wait_done();
      if (vt[i].eof && vt[i].nwords > 0) fc_exp++;
      chk($sformatf("v%0d_nwords", i), 64'(acc_q.size()), 64'(vt[i].nwords));
      for (int k = 0; k < acc_q.size(); k++) begin
        chk($sformatf("v%0d_w%0d_data", i, k), 64'(acc_q[k].d), 64'(base + 32'(k)));
        chk($sformatf("v%0d_w%0d_eof", i, k), 64'(acc_q[k].e),
            64'(vt[i].eof && k == vt[i].nwords - 1));
      end
      chk($sformatf("v%0d_errbe", i), 64'(ErrBe), 64'(vt[i].ebe));
      chk($sformatf("v%0d_errlen", i), 64'(ErrLen), 64'(vt[i].elen));
      chk($sformatf("v%0d_reads", i), 64'(nreads - r0), 1);
      chk($sformatf("v%0d_fc", i), 64'(FrameCount), 64'(fc_exp));
    end

    // two full blocks back to back: 16 words on consecutive cycles, one EOF at the end
    ErrClear = 1'b1; step(); ErrClear = 1'b0;
    acc_q.delete();
    ActiveLanes = 2'd3;
    push(8'hFF, 1'b0, 32'hB000_0000);
    push(8'hFF, 1'b1, 32'hB100_0000);
    wait_done();
    fc_exp++;
    chk("b2b_nwords", 64'(acc_q.size()), 16);
    for (int k = 0; k < acc_q.size(); k++) begin
      chk($sformatf("b2b_w%0d_data", k), 64'(acc_q[k].d),
          64'(k < 8 ? 32'hB000_0000 + 32'(k) : 32'hB100_0000 + 32'(k - 8)));
      chk($sformatf("b2b_w%0d_eof", k), 64'(acc_q[k].e), 64'(k == 15));
      if (k > 0) chk($sformatf("b2b_w%0d_gap", k), 64'(acc_q[k].cyc - acc_q[k-1].cyc), 1);
    end
    chk("b2b_fc", 64'(FrameCount), 64'(fc_exp));

    // backpressure mid-block and on the last word with a second block waiting
    acc_q.delete();
    ReadyOut = 1'b0;
    push(8'hFF, 1'b1, 32'hC000_0000);
    push(8'h0F, 1'b1, 32'hC100_0000);
    step(); step();
    @(negedge Clk);
    chk("bp_first_data", 64'(DataOut), 64'h0000_0000_C000_0000);
    chk("bp_first_valid", 64'(ValidOut), 1);
    step();
    ReadyOut = 1'b1;
    step(); step();
    ReadyOut = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge Clk);
      chk($sformatf("bp_mid%0d_data", s), 64'(DataOut), 64'h0000_0000_C000_0002);
      chk($sformatf("bp_mid%0d_eof", s), 64'(EofOut), 0);
      chk($sformatf("bp_mid%0d_inread", s), 64'(InRead), 0);
      step();
    end
    ReadyOut = 1'b1;
    for (int s = 0; s < 5; s++) step();
    ReadyOut = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge Clk);
      chk($sformatf("bp_last%0d_data", s), 64'(DataOut), 64'h0000_0000_C000_0007);
      chk($sformatf("bp_last%0d_eof", s), 64'(EofOut), 1);
      chk($sformatf("bp_last%0d_valid", s), 64'(ValidOut), 1);
      chk($sformatf("bp_last%0d_inread", s), 64'(InRead), 0);
      step();
    end
    ReadyOut = 1'b1;
    wait_done();
    fc_exp += 2;
    chk("bp_nwords", 64'(acc_q.size()), 12);
    for (int k = 0; k < acc_q.size(); k++) begin
      chk($sformatf("bp_w%0d_data", k), 64'(acc_q[k].d),
          64'(k < 8 ? 32'hC000_0000 + 32'(k) : 32'hC100_0000 + 32'(k - 8)));
      chk($sformatf("bp_w%0d_eof", k), 64'(acc_q[k].e), 64'(k == 7 || k == 11));
    end
    chk("bp_fc", 64'(FrameCount), 64'(fc_exp));

    // asynchronous reset while idx=2 of an 8-word block
    acc_q.delete();
    push(8'hFF, 1'b1, 32'hD000_0000);
    step(); step(); step();
    chk("rst_mid_pre_data", 64'(DataOut), 64'h0000_0000_D000_0002);
    Reset_n = 1'b0;
    #1;
    fc_exp = 0;
    chk("rst_mid_valid", 64'(ValidOut), 0);
    chk("rst_mid_data", 64'(DataOut), 0);
    chk("rst_mid_eof", 64'(EofOut), 0);
    chk("rst_mid_fc", 64'(FrameCount), 0);
    chk("rst_mid_wfc", 64'(w_FrameCount), 0);
    step();
    Reset_n = 1'b1;
    acc_q.delete();
    push(8'h0F, 1'b1, 32'hD100_0000);
    wait_done();
    fc_exp++;
    chk("rst_after_nwords", 64'(acc_q.size()), 4);
    for (int k = 0; k < acc_q.size(); k++)
      chk($sformatf("rst_after_w%0d", k), 64'(acc_q[k].d), 64'(32'hD100_0000 + 32'(k)));
    chk("rst_after_fc", 64'(FrameCount), 64'(fc_exp));

    // counter wrap on the 4-bit copy: 15 -> 0 on the sixteenth EOF
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    fc_exp = 0;
    acc_q.delete();
    for (int i = 0; i < 15; i++) push(8'h01, 1'b1, 32'hE000_0000 + 32'(i * 16));
    wait_done();
    fc_exp += 15;
    chk("wrap_pre_wfc", 64'(w_FrameCount), 15);
    chk("wrap_pre_fc", 64'(FrameCount), 64'(fc_exp));
    push(8'h01, 1'b1, 32'hE100_0000);
    wait_done();
    fc_exp++;
    chk("wrap_wfc", 64'(w_FrameCount), 0);
    chk("wrap_fc", 64'(FrameCount), 64'(fc_exp));
    chk("wrap_nwords", 64'(acc_q.size()), 16);
    chk("no_read_when_empty", 64'(illegal), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
